led_sequencer: RTL and testbench

- Clocked controller that drives the select/enable inputs of the ledOnOff LED decoder: dataIn[1:0] and ledOn.
- Steps the decoder through selects 0..LAST_SEL. Each select gets an ON phase of programmable length, then an OFF gap.
- Supports one-shot or repeating runs, with start/stop pulse control and a completion pulse.
- Sits between the board's control logic (buttons or CPU strobe) and the ledOnOff instance; replaces hand-driven dataIn/ledOn stimulus.

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/dwell_timer.sv | 36 +++
 rtl/led_sequencer.sv | 158 +++++++++++++++
 tb/tb_led_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared types and constants for the LED decoder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] c_DATA_RST = '0;
    localparam logic             c_LED_RST  = 1'b0;

    // Counter wide enough to hold the larger of two dwell lengths (min 1 bit).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module      : dwell_timer
// Description : Up-counter with clear, enable and a one-cycle terminal pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == i_tc);

    // Holds at the terminal value until the owner reloads it; never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module      : led_sequencer
// Description : Steps a ledOnOff decoder through selects with ON/OFF dwell.
//               Optional blink during ON enabled by macro LED_SEQ_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int ON_CYC     = 4,
    parameter int GAP_CYC    = 2,
    parameter int LAST_SEL   = 2,
    parameter int BLINK_HALF = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_en,
    output logic [SEL_W-1:0] dataIn,
    output logic             ledOn,
    output logic             busy,
    output logic             seq_done
);

    localparam int               CNT_W     = cnt_width(ON_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0] c_ON_TC   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] c_GAP_TC  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam bit               c_HAS_GAP = (GAP_CYC > 0);
    localparam logic [SEL_W-1:0] c_LAST    = SEL_W'(LAST_SEL);

    // Unsupported configurations elaborate an empty marker block only.
    if (ON_CYC < 1 || LAST_SEL < 0 || LAST_SEL > 3 || BLINK_HALF < 1) begin : g_cfg_invalid
    end

    state_t           r_state;
    state_t           w_nxt_state;
    state_t           w_adv_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_nxt_sel;
    logic [SEL_W-1:0] w_adv_sel;
    logic             w_at_last;
    logic             w_load;
    logic             w_en;
    logic [CNT_W-1:0] w_tc;
    logic             w_expire;
    logic             w_led_nxt;

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_en     (w_en),
        .i_tc     (w_tc),
        .o_expire (w_expire)
    );

    assign w_at_last   = (r_sel == c_LAST);
    assign w_adv_state = (!w_at_last || repeat_en) ? ST_ON : ST_DONE;
    assign w_adv_sel   = w_at_last ? '0 : r_sel + SEL_W'(1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_tc        = c_ON_TC;
        unique case (r_state)
            ST_IDLE: begin
                w_load = 1'b1;
                if (start && !stop) begin
                    w_nxt_state = ST_ON;
                    w_nxt_sel   = '0;
                end
            end
            ST_ON: begin
                w_en = 1'b1;
                if (w_expire) begin
                    w_load = 1'b1;
                    if (c_HAS_GAP) begin
                        w_nxt_state = ST_GAP;
                    end else begin
                        w_nxt_state = w_adv_state;
                        w_nxt_sel   = w_adv_sel;
                    end
                end
            end
            ST_GAP: begin
                w_en = 1'b1;
                w_tc = c_GAP_TC;
                if (w_expire) begin
                    w_load      = 1'b1;
                    w_nxt_state = w_adv_state;
                    w_nxt_sel   = w_adv_sel;
                end
            end
            default: begin
                w_load      = 1'b1;
                w_nxt_state = ST_IDLE;
                w_nxt_sel   = '0;
            end
        endcase
        // Abort overrides every transition out of a busy state.
        if (stop && r_state != ST_IDLE) begin
            w_nxt_state = ST_IDLE;
            w_nxt_sel   = '0;
            w_load      = 1'b1;
            w_en        = 1'b0;
        end
    end

`ifdef LED_SEQ_BLINK_EN
    localparam int               BLK_W      = cnt_width(BLINK_HALF, 1);
    localparam logic [BLK_W-1:0] c_BLINK_TC = BLK_W'(BLINK_HALF - 1);

    logic w_on_stay;
    logic w_blink_exp;

    assign w_on_stay = (r_state == ST_ON) && (w_nxt_state == ST_ON) && !w_load;

    dwell_timer #(.CNT_W(BLK_W)) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (!w_on_stay || w_blink_exp),
        .i_en     (r_state == ST_ON),
        .i_tc     (c_BLINK_TC),
        .o_expire (w_blink_exp)
    );

    // Each ON entry restarts high; staying in ON toggles on every half period.
    assign w_led_nxt = w_on_stay ? (ledOn ^ w_blink_exp) : (w_nxt_state == ST_ON);
`else
    assign w_led_nxt = (w_nxt_state == ST_ON);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            dataIn   <= c_DATA_RST;
            ledOn    <= c_LED_RST;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_sel    <= w_nxt_sel;
            dataIn   <= (w_nxt_state == ST_ON || w_nxt_state == ST_GAP) ? w_nxt_sel : c_DATA_RST;
            ledOn    <= w_led_nxt;
            busy     <= (w_nxt_state != ST_IDLE);
            seq_done <= (w_nxt_state == ST_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module      : tb_led_sequencer
// Description : Directed vector bench for led_sequencer (default and no-gap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, rep = 1'b0;
    logic [1:0] dataIn;
    logic       ledOn, busy, seq_done;
    logic       start2 = 1'b0, stop2 = 1'b0, rep2 = 1'b0;
    logic [1:0] dataIn2;
    logic       ledOn2, busy2, seq_done2;

    always #5 clk = ~clk;

    led_sequencer #(.ON_CYC(4), .GAP_CYC(2), .LAST_SEL(2), .BLINK_HALF(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(rep),
        .dataIn(dataIn), .ledOn(ledOn), .busy(busy), .seq_done(seq_done)
    );

    led_sequencer #(.ON_CYC(4), .GAP_CYC(0), .LAST_SEL(2), .BLINK_HALF(1)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .repeat_en(rep2),
        .dataIn(dataIn2), .ledOn(ledOn2), .busy(busy2), .seq_done(seq_done2)
    );

    // led code: 0 = off, k = k-th cycle (1-based) of an ON phase
    typedef struct {
        logic       st;
        logic       sp;
        logic       rp;
        logic [1:0] d;
        int         l;
        logic       b;
        logic       s;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic exp_led(input int code);
        if (code == 0) return 1'b0;
`ifdef LED_SEQ_BLINK_EN
        return ((code - 1) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic add(input logic st, input logic sp, input logic rp,
                       input logic [1:0] d, input int l, input logic b, input logic s);
        vec_t v;
        v.st = st; v.sp = sp; v.rp = rp; v.d = d; v.l = l; v.b = b; v.s = s;
        vecs.push_back(v);
    endtask

    // First n cycles of a pass through selects 0..2 (4 ON + 2 GAP each).
    task automatic add_pass(input logic st0, input logic st_rest, input logic rp0,
                            input logic rp_rest, input int n);
        int k;
        k = 0;
        for (int sel = 0; sel < 3; sel++) begin
            for (int c = 0; c < 6; c++) begin
                if (k < n)
                    add((k == 0) ? st0 : st_rest, 1'b0, (k == 0) ? rp0 : rp_rest,
                        2'(sel), (c < 4) ? c + 1 : 0, 1'b1, 1'b0);
                k++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {dataIn,ledOn,busy,seq_done}=%b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {dataIn, ledOn, busy, seq_done}, 5'b0);
        chk("reset_nogap", {dataIn2, ledOn2, busy2, seq_done2}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, then start+stop together must stay idle
        add(0, 0, 0, 2'd0, 0, 0, 0);
        add(1, 1, 0, 2'd0, 0, 0, 0);
        add(0, 0, 0, 2'd0, 0, 0, 0);
        // One-shot run, start held high while busy (must be ignored)
        add_pass(1, 1, 0, 0, 18);
        add(0, 0, 0, 2'd0, 0, 1, 1);
        add(0, 0, 0, 2'd0, 0, 0, 0);
        add(0, 0, 0, 2'd0, 0, 0, 0);
        // Repeat: wrap once, drop repeat_en during second pass
        add_pass(1, 0, 1, 1, 18);
        add_pass(0, 0, 1, 0, 18);
        add(0, 0, 0, 2'd0, 0, 1, 1);
        add(0, 0, 0, 2'd0, 0, 0, 0);
        // Repeat with repeat_en=1 at the last gap of a run then stop in ON
        add_pass(1, 0, 1, 1, 18);
        add(0, 0, 1, 2'd0, 1, 1, 0);
        add(0, 1, 1, 2'd0, 0, 0, 0);
        // Stop during first GAP cycle of sel=1
        add_pass(1, 0, 0, 0, 11);
        add(0, 1, 0, 2'd0, 0, 0, 0);
        add(0, 0, 0, 2'd0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st;
            stop  = vecs[i].sp;
            rep   = vecs[i].rp;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {dataIn, ledOn, busy, seq_done},
                {vecs[i].d, exp_led(vecs[i].l), vecs[i].b, vecs[i].s});
        end
        start = 1'b0; stop = 1'b0; rep = 1'b0;

        // Asynchronous reset in the middle of an ON phase
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_async_rst", {dataIn, ledOn, busy, seq_done}, {2'd0, exp_led(2), 1'b1, 1'b0});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {dataIn, ledOn, busy, seq_done}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {dataIn, ledOn, busy, seq_done}, 5'b0);

        // No-gap instance: select advances every 4 cycles, start while busy ignored
        start2 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nogap%0d", k), {dataIn2, ledOn2, busy2, seq_done2},
                {2'(k / 4), exp_led((k % 4) + 1), 1'b1, 1'b0});
            if (k == 7) start2 = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("nogap_done", {dataIn2, ledOn2, busy2, seq_done2}, 5'b00011);
        @(posedge clk);
        #1;
        chk("nogap_idle", {dataIn2, ledOn2, busy2, seq_done2}, 5'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
